// File: rtl/mux_read_arbiter.sv
// -----------------------------------------------------------------------------
// mux_read_arbiter
//
// Shares the single read port of a 512-entry (2**ADDR) table mux among NREQ
// read clients (fetch, operand read, debug, ...). Each cycle at most one
// requester is granted in round-robin order. The granted index is registered
// onto sel_o. The mux output, which settles combinationally from sel_o, is
// captured one cycle later into a response register. That register is returned
// together with the ID of the requester that owns it.
//
// Ports
//   clk_i        in   1            clock, rising edge
//   rst_ni       in   1            asynchronous reset, active-low
//   req_valid_i  in   NREQ         per-requester read request
//   req_addr_i   in   NREQ*ADDR    per-requester entry index (requester r in
//                                  bits [r*ADDR +: ADDR])
//   req_ready_o  out  NREQ         one-hot grant
//   sel_o        out  ADDR         registered select to the mux
//   mux_data_i   in   N            mux output, combinational from sel_o
//   rsp_valid_o  out  1            response register holds valid data
//   rsp_id_o     out  IDW          requester that owns the response
//   rsp_data_o   out  N            captured entry data
//   rsp_ready_i  in   1            consumer accepts the response
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. A valid source keeps its payload stable until that transfer. ready may
// depend combinationally on valid. The request side has no obligation to keep
// valid asserted while it is not granted: dropping a request or changing its
// address before the grant has no side effects.
// -----------------------------------------------------------------------------
module mux_read_arbiter #(
    parameter int N    = 4,
    parameter int ADDR = 9,
    parameter int NREQ = 4,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NREQ-1:0]        req_valid_i,
    input  logic [NREQ*ADDR-1:0]   req_addr_i,
    output logic [NREQ-1:0]        req_ready_o,
    output logic [ADDR-1:0]        sel_o,
    input  logic [N-1:0]           mux_data_i,
    output logic                   rsp_valid_o,
    output logic [IDW-1:0]         rsp_id_o,
    output logic [N-1:0]           rsp_data_o,
    input  logic                   rsp_ready_i
);

    // Pipeline stage S1: an accepted request whose address is on sel_o. The
    // mux output for that address is settling during this cycle.
    logic           s1_valid;
    logic [IDW-1:0] s1_id;

    // Requester searched first in the next arbitration round.
    logic [IDW-1:0] rr_ptr;

    logic           adv_rsp;
    logic           adv_s1;
    logic           grant_en;
    logic           grant;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] winner_next;
    logic [IDW:0]   cand;
    logic           found;

    // Advance rules. The response register frees up when empty or when
    // drained this cycle. S1 may move forward when it is empty or when the
    // response register can take its contents. A drain and a new capture in
    // the same cycle are allowed, so the stream has no bubble.
    assign adv_rsp  = !rsp_valid_o || rsp_ready_i;
    assign adv_s1   = !s1_valid || adv_rsp;
    // Grants are suppressed while reset is held. Otherwise a requester could
    // see a handshake that the reset then throws away.
    assign grant_en = adv_s1 && rst_ni;

    // Round-robin search starting at rr_ptr, wrapping NREQ-1 -> 0. cand is one
    // bit wider than an ID, so rr_ptr + i cannot overflow before the wrap.
    always_comb begin
        winner      = '0;
        found       = 1'b0;
        cand        = '0;
        req_ready_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!found && req_valid_i[cand[IDW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDW-1:0];
            end
        end
        if (grant_en && found) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    assign grant = grant_en && found;

    // Pointer moves to the requester just after the winner, so the winner has
    // the lowest priority in the next round.
    assign winner_next = (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;

    // Stage S1 and the select register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            sel_o    <= '0;
            rr_ptr   <= '0;
        end else begin
            if (grant) begin
                s1_valid <= 1'b1;
                s1_id    <= winner;
                sel_o    <= req_addr_i[int'(winner)*ADDR +: ADDR];
                rr_ptr   <= winner_next;
            end else if (adv_s1) begin
                // sel_o keeps its last value, so the mux input does not toggle
                // while idle.
                s1_valid <= 1'b0;
            end
        end
    end

    // Response register. mux_data_i belongs to the S1 entry because sel_o was
    // loaded on the same edge that filled S1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= '0;
            rsp_data_o  <= '0;
        end else begin
            if (s1_valid && adv_rsp) begin
                rsp_valid_o <= 1'b1;
                rsp_id_o    <= s1_id;
                rsp_data_o  <= mux_data_i;
            end else if (adv_rsp) begin
                rsp_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_read_arbiter
//
// Bench for mux_read_arbiter with N=8, NREQ=4, ADDR=9. The table mux is
// modelled as entry k = k[7:0] ^ 8'h5A. The reference model is an in-order
// scoreboard queue of accepted requests ({id, data}) plus a round-robin
// pointer. It tracks occupancy as "head is presented to the consumer" and
// "items behind it".
// -----------------------------------------------------------------------------
module tb_mux_read_arbiter;

    logic        clk;
    logic        rst_ni;
    logic [3:0]  req_valid_i;
    logic [35:0] req_addr_i;
    logic [3:0]  req_ready_o;
    logic [8:0]  sel_o;
    logic [7:0]  mux_data_i;
    logic        rsp_valid_o;
    logic [1:0]  rsp_id_o;
    logic [7:0]  rsp_data_o;
    logic        rsp_ready_i;

    mux_read_arbiter #(.N(8), .ADDR(9), .NREQ(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_addr_i  (req_addr_i),
        .req_ready_o (req_ready_o),
        .sel_o       (sel_o),
        .mux_data_i  (mux_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_id_o    (rsp_id_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_ready_i (rsp_ready_i)
    );

    // Table mux model
    assign mux_data_i = sel_o[7:0] ^ 8'h5A;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [9:0] exp_q[$];   // {id, data} accepted, not yet consumed
    bit         m_rv;       // head of exp_q is presented on the response port
    int         m_rr;       // round-robin start
    logic [8:0] m_sel;      // last granted address

    // Per-cycle observations and expectations
    logic [3:0] obs_ready, exp_ready;
    logic       obs_rv, exp_rv;
    logic [9:0] obs_item, exp_item;
    logic [8:0] obs_sel, exp_sel;

    task automatic model_reset();
        exp_q.delete();
        m_rv  = 0;
        m_rr  = 0;
        m_sel = '0;
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        req_valid_i = '0;
        req_addr_i  = '0;
        rsp_ready_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    // One clock cycle, entered and left just after a negedge. The task applies
    // the inputs, samples the grant, steps the model across the posedge and
    // samples the registered outputs. It compares nothing.
    task automatic cycle(input logic [3:0] v, input logic [35:0] a, input logic rr);
        int  s1_n;
        bit  adv_rsp;
        bit  gok;
        int  w;
        int  idx;
        req_valid_i = v;
        req_addr_i  = a;
        rsp_ready_i = rr;
        s1_n    = exp_q.size() - (m_rv ? 1 : 0);
        adv_rsp = !m_rv || rr;
        gok     = (s1_n == 0) || adv_rsp;
        w = -1;
        if (gok) begin
            for (int i = 0; i < 4; i++) begin
                idx = (m_rr + i) % 4;
                if (w < 0 && v[idx]) w = idx;
            end
        end
        exp_ready = (w >= 0) ? (4'b0001 << w) : 4'b0000;
        #1;
        obs_ready = req_ready_o;
        @(posedge clk);
        if (m_rv && rr) void'(exp_q.pop_front());
        if (adv_rsp) m_rv = (s1_n > 0);
        if (w >= 0) begin
            exp_q.push_back({2'(w), a[w*9 +: 8] ^ 8'h5A});
            m_rr  = (w + 1) % 4;
            m_sel = a[w*9 +: 9];
        end
        #1;
        obs_rv   = rsp_valid_o;
        obs_item = {rsp_id_o, rsp_data_o};
        obs_sel  = sel_o;
        exp_rv   = m_rv;
        exp_item = m_rv ? exp_q[0] : 10'h0;
        exp_sel  = m_sel;
        @(negedge clk);
    endtask

    function automatic logic [35:0] rand_addrs();
        return {4'($urandom), $urandom};
    endfunction

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst_ni      = 1'b0;
        req_valid_i = 4'hF;
        req_addr_i  = rand_addrs();
        rsp_ready_i = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++; if (req_ready_o !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b want 0000", req_ready_o); end
        tests++; if (sel_o !== 9'd0) begin fails++; $display("FAIL reset_sel got %0d want 0", sel_o); end
        tests++; if (rsp_valid_o !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid_o); end
        tests++; if ({rsp_id_o, rsp_data_o} !== 10'h0) begin fails++; $display("FAIL reset_rsp_id_data got %h want 000", {rsp_id_o, rsp_data_o}); end
        @(negedge clk);
        req_valid_i = '0;
        rst_ni = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        cycle(4'b0001, 36'd3, 1'b1);
        tests++; if (obs_ready !== 4'b0001) begin fails++; $display("FAIL single_ready got %b want 0001", obs_ready); end
        tests++; if (obs_sel !== 9'd3) begin fails++; $display("FAIL single_sel got %0d want 3", obs_sel); end
        tests++; if (obs_rv !== 1'b0) begin fails++; $display("FAIL single_early_valid got %b want 0", obs_rv); end
        cycle(4'b0000, 36'd0, 1'b1);
        tests++; if (obs_rv !== 1'b1) begin fails++; $display("FAIL single_valid got %b want 1", obs_rv); end
        tests++; if (obs_item !== {2'd0, 8'h59}) begin fails++; $display("FAIL single_data got %h want 059", obs_item); end
        cycle(4'b0000, 36'd0, 1'b1);
        tests++; if (obs_rv !== exp_rv) begin fails++; $display("FAIL single_drain got %b want %b", obs_rv, exp_rv); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] want[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int c = 0; c < 9; c++) begin
            cycle(c < 5 ? 4'hF : 4'h0, rand_addrs(), 1'b1);
            if (c < 5) begin
                tests++; if (obs_ready !== want[c]) begin fails++; $display("FAIL b2b_grant%0d got %b want %b", c, obs_ready, want[c]); end
            end
            if (c >= 1 && c <= 5) begin
                tests++; if (obs_rv !== 1'b1) begin fails++; $display("FAIL b2b_bubble%0d got %b want 1", c, obs_rv); end
            end
            tests++; if (obs_ready !== exp_ready) begin fails++; $display("FAIL b2b_ready got %b want %b", obs_ready, exp_ready); end
            tests++; if (obs_rv !== exp_rv) begin fails++; $display("FAIL b2b_valid got %b want %b", obs_rv, exp_rv); end
            tests++; if (obs_sel !== exp_sel) begin fails++; $display("FAIL b2b_sel got %0d want %0d", obs_sel, exp_sel); end
            if (exp_rv) begin
                tests++; if (obs_item !== exp_item) begin fails++; $display("FAIL b2b_item got %h want %h", obs_item, exp_item); end
            end
        end
    endtask

    task automatic test_boundary_addr();
        logic [35:0] a;
        do_reset();
        cycle(4'b0010, 36'd0, 1'b1);            // grant req1, rr_ptr -> 2
        cycle(4'b0000, 36'd0, 1'b1);
        a = '0;
        a[17:9]  = 9'd511;
        a[26:18] = 9'd0;
        cycle(4'b0110, a, 1'b1);
        tests++; if (obs_ready !== 4'b0100) begin fails++; $display("FAIL bound_first got %b want 0100", obs_ready); end
        cycle(4'b0010, a, 1'b1);
        tests++; if (obs_ready !== 4'b0010) begin fails++; $display("FAIL bound_second got %b want 0010", obs_ready); end
        tests++; if (obs_item !== {2'd2, 8'h5A}) begin fails++; $display("FAIL bound_data0 got %h want 25a", obs_item); end
        cycle(4'b0000, a, 1'b1);
        tests++; if (obs_item !== {2'd1, 8'hA5}) begin fails++; $display("FAIL bound_data511 got %h want 1a5", obs_item); end
        tests++; if (obs_sel !== 9'd511) begin fails++; $display("FAIL bound_sel got %0d want 511", obs_sel); end
        cycle(4'b0000, a, 1'b1);
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int c = 0; c < 18; c++) begin
            logic rr;
            rr = !(c >= 3 && c < 8);
            cycle(c < 12 ? 4'b0001 : 4'b0000, rand_addrs(), rr);
            if (c >= 4 && c < 8) begin
                tests++; if (obs_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready%0d got %b want 0000", c, obs_ready); end
            end
            tests++; if (obs_ready !== exp_ready) begin fails++; $display("FAIL bp_ready got %b want %b", obs_ready, exp_ready); end
            tests++; if (obs_rv !== exp_rv) begin fails++; $display("FAIL bp_valid got %b want %b", obs_rv, exp_rv); end
            tests++; if (obs_sel !== exp_sel) begin fails++; $display("FAIL bp_sel got %0d want %0d", obs_sel, exp_sel); end
            if (exp_rv) begin
                tests++; if (obs_item !== exp_item) begin fails++; $display("FAIL bp_item got %h want %h", obs_item, exp_item); end
            end
        end
        tests++; if (obs_rv !== 1'b0) begin fails++; $display("FAIL bp_drained got %b want 0", obs_rv); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 4; c++) cycle(4'hF, rand_addrs(), 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        tests++; if (rsp_valid_o !== 1'b0) begin fails++; $display("FAIL arst_valid got %b want 0", rsp_valid_o); end
        tests++; if (sel_o !== 9'd0) begin fails++; $display("FAIL arst_sel got %0d want 0", sel_o); end
        tests++; if (req_ready_o !== 4'b0000) begin fails++; $display("FAIL arst_ready got %b want 0000", req_ready_o); end
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        cycle(4'b1010, rand_addrs(), 1'b1);
        tests++; if (obs_ready !== 4'b0010) begin fails++; $display("FAIL arst_first got %b want 0010", obs_ready); end
        cycle(4'b0000, 36'd0, 1'b1);
        tests++; if (obs_item !== exp_item) begin fails++; $display("FAIL arst_item got %h want %h", obs_item, exp_item); end
        cycle(4'b0000, 36'd0, 1'b1);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            cycle(4'b1000, rand_addrs(), 1'b1);
            tests++; if (obs_ready !== 4'b1000) begin fails++; $display("FAIL wrap_grant%0d got %b want 1000", c, obs_ready); end
        end
        // Pointer is back at 0, so req0 beats req3.
        cycle(4'b1001, rand_addrs(), 1'b1);
        tests++; if (obs_ready !== 4'b0001) begin fails++; $display("FAIL wrap_ptr got %b want 0001", obs_ready); end
        tests++; if (obs_item !== exp_item) begin fails++; $display("FAIL wrap_item got %h want %h", obs_item, exp_item); end
        cycle(4'b0000, 36'd0, 1'b1);
        cycle(4'b0000, 36'd0, 1'b1);
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [35:0] a;
            a = rand_addrs();
            if ($urandom_range(0, 7) == 0) a[8:0]   = 9'd511;
            if ($urandom_range(0, 7) == 0) a[35:27] = 9'd0;
            cycle(c < 390 ? 4'($urandom_range(0, 15)) : 4'h0, a, $urandom_range(0, 3) != 0 || c >= 390);
            tests++; if (obs_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready c=%0d got %b want %b", c, obs_ready, exp_ready); end
            tests++; if (obs_rv !== exp_rv) begin fails++; $display("FAIL rnd_valid c=%0d got %b want %b", c, obs_rv, exp_rv); end
            tests++; if (obs_sel !== exp_sel) begin fails++; $display("FAIL rnd_sel c=%0d got %0d want %0d", c, obs_sel, exp_sel); end
            if (exp_rv) begin
                tests++; if (obs_item !== exp_item) begin fails++; $display("FAIL rnd_item c=%0d got %h want %h", c, obs_item, exp_item); end
            end
        end
        tests++; if (exp_q.size() != 0 || obs_rv !== 1'b0) begin fails++; $display("FAIL rnd_leftover got %0d/%b want 0/0", exp_q.size(), obs_rv); end
    endtask

    initial begin
        rst_ni      = 1'b0;
        req_valid_i = '0;
        req_addr_i  = '0;
        rsp_ready_i = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_boundary_addr();
        test_backpressure();
        test_async_reset();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
